// File: rtl/free_list_ckpt.sv
// rtl/free_list_ckpt.sv - multi-lane circular free list with head-pointer checkpoints
// All-or-nothing get/put groups; restore rewinds head to a saved slot.
module free_list_ckpt #(
    parameter int DEPTH     = 64,
    parameter int WIDTH     = 6,
    parameter int GET_PORTS = 3,
    parameter int PUT_PORTS = 3,
    parameter int NUM_CKPT  = 4,
    parameter int INIT_FILL = 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [GET_PORTS-1:0]                              get_en,
    output logic [GET_PORTS-1:0][WIDTH-1:0]                   gotten,
    output logic                                              get_ok,
    input  logic [PUT_PORTS-1:0]                              put_en,
    input  logic [PUT_PORTS-1:0][WIDTH-1:0]                   put,
    output logic                                              put_ok,
    output logic [$clog2(DEPTH):0]                            len,
    input  logic                                              ckpt_save,
    input  logic [((NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1)-1:0] ckpt_save_id,
    input  logic                                              ckpt_restore,
    input  logic [((NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1)-1:0] ckpt_restore_id,
    output logic                                              err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [WIDTH-1:0] r_mem  [DEPTH];
    logic [PW-1:0]    r_ckpt [NUM_CKPT];
    logic             r_err;

    logic [PW:0]   w_ng;
    logic [PW:0]   w_np;
    logic [PW:0]   w_len_x;
    logic [PW:0]   w_space;
    logic [PW-1:0] w_goff [GET_PORTS];
    logic [PW-1:0] w_poff [PUT_PORTS];
    logic [PW-1:0] w_tail_next;
    logic [PW-1:0] w_head_next;
    logic [PW-1:0] w_rest_head;
    logic [PW-1:0] w_rest_occ;
    logic          w_rest_legal;
    logic          w_err_set;

    assign len     = r_tail - r_head;
    assign err     = r_err;
    assign w_len_x = {1'b0, len};
    assign w_space = (PW+1)'(DEPTH) - w_len_x;

    // Exclusive prefix sums pack the enabled lanes in lane order.
    always_comb begin
        w_ng = '0;
        for (int i = 0; i < GET_PORTS; i++) begin
            w_goff[i] = w_ng[PW-1:0];
            w_ng      = w_ng + {{PW{1'b0}}, get_en[i]};
        end
        w_np = '0;
        for (int j = 0; j < PUT_PORTS; j++) begin
            w_poff[j] = w_np[PW-1:0];
            w_np      = w_np + {{PW{1'b0}}, put_en[j]};
        end
    end

    assign get_ok = (w_ng <= w_len_x) && !ckpt_restore && !rst;
    assign put_ok = (w_np <= w_space) && !rst;

    always_comb begin
        for (int i = 0; i < GET_PORTS; i++) begin
            gotten[i] = '0;
            if (get_ok && get_en[i]) begin
                gotten[i] = r_mem[AW'(r_head + w_goff[i])];
            end
        end
    end

    assign w_tail_next  = r_tail + (put_ok ? w_np[PW-1:0] : {PW{1'b0}});
    assign w_rest_head  = r_ckpt[ckpt_restore_id];
    assign w_rest_occ   = w_tail_next - w_rest_head;
    assign w_rest_legal = ({1'b0, w_rest_occ} <= (PW+1)'(DEPTH));

    always_comb begin
        w_head_next = r_head;
        if (ckpt_restore) begin
            if (w_rest_legal) begin
                w_head_next = w_rest_head;
            end
        end else if (get_ok) begin
            w_head_next = r_head + w_ng[PW-1:0];
        end
    end

    assign w_err_set = (!ckpt_restore && (w_ng != '0) && (w_ng > w_len_x))
                     || (w_np > w_space)
                     || (ckpt_restore && !w_rest_legal);

    // Saving after the head mux lets a same-slot save+restore capture the restored head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= (INIT_FILL != 0) ? PW'(DEPTH) : '0;
            r_err  <= 1'b0;
            for (int c = 0; c < NUM_CKPT; c++) begin
                r_ckpt[c] <= '0;
            end
        end else begin
            r_head <= w_head_next;
            r_tail <= w_tail_next;
            if (ckpt_save) begin
                r_ckpt[ckpt_save_id] <= w_head_next;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (INIT_FILL != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= WIDTH'(i);
                end
            end
        end else if (put_ok) begin
            for (int j = 0; j < PUT_PORTS; j++) begin
                if (put_en[j]) begin
                    r_mem[AW'(r_tail + w_poff[j])] <= put[j];
                end
            end
        end
    end

endmodule

// File: doc/free_list_ckpt.md
FREE_LIST_CKPT -- requirements
Module: free_list_ckpt

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the entry count; must be a power of two and at least 2.
REQ-002 SHALL have parameter WIDTH, default 6, meaning the bits per entry.
REQ-003 SHALL have parameter GET_PORTS, default 3, meaning the number of dequeue lanes.
REQ-004 SHALL have parameter PUT_PORTS, default 3, meaning the number of enqueue lanes.
REQ-005 SHALL have parameter NUM_CKPT, default 4, meaning the number of head-pointer checkpoint slots.
REQ-006 SHALL have parameter INIT_FILL, default 1: 1 means reset leaves the queue full with entry i = i[WIDTH-1:0]; 0 means reset leaves it empty.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port get_en, input, 1 bit x GET_PORTS: per-lane dequeue request.
REQ-010 SHALL have port gotten, output, WIDTH x GET_PORTS: dequeued values, combinational, same cycle.
REQ-011 SHALL have port get_ok, output, 1 bit: the whole get group is granted this cycle.
REQ-012 SHALL have port put_en, input, 1 bit x PUT_PORTS: per-lane enqueue request.
REQ-013 SHALL have port put, input, WIDTH x PUT_PORTS: enqueue data.
REQ-014 SHALL have port put_ok, output, 1 bit: the whole put group is accepted this cycle.
REQ-015 SHALL have port len, output, clog2(DEPTH)+1 bits: registered occupancy, 0..DEPTH.
REQ-016 SHALL have port ckpt_save, input, 1 bit, and ckpt_save_id, input, clog2(NUM_CKPT) bits: save the next head pointer into the selected slot.
REQ-017 SHALL have port ckpt_restore, input, 1 bit, and ckpt_restore_id, input, clog2(NUM_CKPT) bits: reload the head pointer from the selected slot.
REQ-018 SHALL have port err, output, 1 bit: sticky flag, set on any rejected get, rejected put, or illegal restore.

Function
REQ-019 SHALL hold head and tail pointers of clog2(DEPTH)+1 bits (MSB is the wrap bit); occupancy SHALL equal tail-head modulo 2^(clog2(DEPTH)+1), and len SHALL equal that value.
REQ-020 SHALL count ng = popcount(get_en) and np = popcount(put_en); lane offsets SHALL be exclusive prefix sums over the enable bits, so enabled lanes are packed in lane order.
REQ-021 SHALL grant gets all-or-nothing: get_ok = (ng <= len) && !ckpt_restore && !rst.
REQ-022 SHALL drive, when get_ok is 1, gotten[i] = mem[(head + goff[i]) mod DEPTH] for each enabled lane i; gotten SHALL be 0 for disabled lanes or when get_ok is 0.
REQ-023 SHALL, when get_ok is 1, advance head by ng at the clock edge; when get_ok is 0, head SHALL stay unchanged and no entry is consumed.
REQ-024 SHALL accept puts all-or-nothing: put_ok = (np <= DEPTH - len) && !rst; the check uses start-of-cycle len, so space freed by a same-cycle get is not usable (no bypass).
REQ-025 SHALL, when put_ok is 1, write put[j] to mem[(tail + poff[j]) mod DEPTH] for each enabled lane j and advance tail by np.
REQ-026 SHALL treat np = 0 or ng = 0 as trivially granted (ok = 1) with no state change for that side.
REQ-027 SHALL, on ckpt_save, store into slot ckpt_save_id the head value being registered at this edge (after any restore or get).
REQ-028 SHALL, on ckpt_restore, set head to slot ckpt_restore_id and suppress gets that cycle; puts in the same cycle still apply.
REQ-029 SHALL treat a restore whose resulting occupancy (tail_next - saved head) exceeds DEPTH as illegal: head is unchanged and err is set.
REQ-030 SHALL give a save and a restore to the same slot in the same cycle this result: the slot receives the restored head.
REQ-031 SHALL set err, which stays 1 until reset, whenever ng > 0 && ng > len without a restore, or np > DEPTH - len.

Reset
REQ-032 SHALL, while rst is high at an edge: head = 0; tail = DEPTH if INIT_FILL else 0; mem[i] = i if INIT_FILL; all checkpoint slots = 0; err = 0.
REQ-033 SHALL set len to DEPTH if INIT_FILL else 0 in the cycle after reset.
REQ-034 SHALL hold get_ok and put_ok at 0 and gotten at 0 during rst; a reset asserted mid-operation SHALL discard all in-flight requests.

Verification
REQ-035 SHALL cover: DEPTH=64, INIT_FILL=1, after reset apply get_en={1,0,1} -> gotten[0]=0, gotten[2]=1, get_ok=1; next cycle len=62.
REQ-036 SHALL cover: len=2, get_en={1,1,1} -> get_ok=0, gotten all 0, len stays 2, err=1.
REQ-037 SHALL cover: INIT_FILL=1 (len=64), get 3 and put 3 in the same cycle -> get_ok=1, put_ok=0, len=61 next cycle.
REQ-038 SHALL cover: head=5, ckpt_save id=1, then two cycles of 3-lane gets (len drops by 6), then ckpt_restore id=1 -> next get of 3 returns 5,6,7.
REQ-039 SHALL cover: INIT_FILL=0; drive tail across index 63 -> 0 with puts 0xA,0xB,0xC at tail=62 -> later gets return 0xA,0xB,0xC in order and len tracks correctly.
REQ-040 SHALL cover: rst asserted mid-burst with get_en and put_en active -> ok outputs 0, state is the REQ-032 values, and len=64 the cycle after.
